// File: rtl/ballot_pkg.sv
// Shared types and constants for the ballot collector and its timeout counter.
package ballot_pkg;

  localparam int NUM_VOTERS      = 5;
  localparam int VOTE_ID_W       = 3;
  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [VOTE_ID_W-1:0] VOTER_ID_MAX = 3'd4;

  // One-hot so each output strobe is a single flop bit.
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    COLLECT = 3'b010,
    DONE    = 3'b100
  } state_e;

endpackage

// File: rtl/ballot_timeout_ctr.sv
// Collection-window counter: cleared when a ballot opens, counts while collecting,
// flags the last permitted cycle.
module ballot_timeout_ctr #(
  parameter int TMR_W          = 8,
  parameter int TIMEOUT_CYCLES = ballot_pkg::TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc_o = (count_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ballot_collector.sv
// Serially collects five voter bits into a ballot vector, closing on a full set
// or on timeout, and strobes ballot_valid for one cycle.
module ballot_collector #(
  parameter int NUM_VOTERS     = ballot_pkg::NUM_VOTERS,
  parameter int TIMEOUT_CYCLES = ballot_pkg::TIMEOUT_DEFAULT,
  parameter int TMR_W          = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            vote_valid,
  input  logic [ballot_pkg::VOTE_ID_W-1:0] vote_id,
  input  logic                            vote_val,
  output logic                            vote_ready,
  output logic [NUM_VOTERS-1:0]           ballot,
  output logic                            ballot_valid,
  output logic                            busy,
  output logic                            timed_out,
  output logic                            dup_err,
  output logic                            id_err
);

  import ballot_pkg::*;

  state_e                state_q;
  logic [NUM_VOTERS-1:0] ballot_q, ballot_d;
  logic [NUM_VOTERS-1:0] mask_q, mask_d;
  logic [NUM_VOTERS-1:0] id_sel;
  logic                  timed_out_q, dup_err_q, id_err_q;
  logic                  in_collect, accept, id_bad, dup_hit, take_vote;
  logic                  tmr_clr, tmr_tc;

  assign in_collect = (state_q == COLLECT);

  for (genvar gi = 0; gi < NUM_VOTERS; gi++) begin : g_id_sel
    assign id_sel[gi] = (vote_id == VOTE_ID_W'(gi));
  end

  // An out-of-range id decodes to no select bit, so it can never write the ballot.
  assign accept    = vote_valid & vote_ready;
  assign id_bad    = (vote_id > VOTER_ID_MAX);
  assign dup_hit   = |(id_sel & mask_q);
  assign take_vote = accept & ~id_bad & ~dup_hit;

  assign mask_d   = take_vote ? (mask_q | id_sel) : mask_q;
  assign ballot_d = take_vote ? ((ballot_q & ~id_sel) | (id_sel & {NUM_VOTERS{vote_val}}))
                              : ballot_q;

  assign tmr_clr = (state_q == IDLE) & start;

  ballot_timeout_ctr #(
    .TMR_W         (TMR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr_i(tmr_clr),
    .en_i (in_collect),
    .tc_o (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ballot_q    <= '0;
      mask_q      <= '0;
      timed_out_q <= 1'b0;
      dup_err_q   <= 1'b0;
      id_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= COLLECT;
            ballot_q    <= '0;
            mask_q      <= '0;
            timed_out_q <= 1'b0;
            dup_err_q   <= 1'b0;
            id_err_q    <= 1'b0;
          end
        end
        COLLECT: begin
          ballot_q <= ballot_d;
          mask_q   <= mask_d;
          if (accept & id_bad)  id_err_q  <= 1'b1;
          if (accept & dup_hit) dup_err_q <= 1'b1;
          // A completing vote wins over a simultaneous timeout.
          if (&mask_d) begin
            state_q <= DONE;
          end else if (tmr_tc) begin
            state_q     <= DONE;
            timed_out_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vote_ready   = in_collect;
  assign busy         = in_collect;
  assign ballot_valid = (state_q == DONE);
  assign ballot       = ballot_q;
  assign timed_out    = timed_out_q;
  assign dup_err      = dup_err_q;
  assign id_err       = id_err_q;

endmodule

// File: tb/tb_ballot_collector.sv
// Randomized and directed bench for ballot_collector against a set-based ballot model.
module tb_ballot_collector;

  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst, start, vote_valid, vote_val;
  logic [2:0] vote_id;
  logic       vote_ready, ballot_valid, busy, timed_out, dup_err, id_err;
  logic [4:0] ballot;

  int n_cmp = 0;
  int n_mis = 0;
  int n_txn = 0;

  bit         vv[T];
  logic [2:0] vid[T];
  bit         vval[T];

  ballot_collector #(
    .NUM_VOTERS    (5),
    .TIMEOUT_CYCLES(T),
    .TMR_W         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vote_valid  (vote_valid),
    .vote_id     (vote_id),
    .vote_val    (vote_val),
    .vote_ready  (vote_ready),
    .ballot      (ballot),
    .ballot_valid(ballot_valid),
    .busy        (busy),
    .timed_out   (timed_out),
    .dup_err     (dup_err),
    .id_err      (id_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < T; k++) begin
      vv[k] = 1'b0; vid[k] = 3'd0; vval[k] = 1'b0;
    end
  endtask

  task automatic set_vote(input int k, input int id, input bit val);
    vv[k] = 1'b1; vid[k] = 3'(id); vval[k] = val;
  endtask

  // Reference: first valid vote per voter wins; window is T collect cycles
  // unless all five voters have been heard.
  task automatic model(output logic [4:0] b, output bit to, output bit de,
                       output bit ie, output int kd);
    bit got[5];
    int n_got, idx;
    b = '0; to = 1'b1; de = 1'b0; ie = 1'b0; kd = T - 1; n_got = 0;
    for (int i = 0; i < 5; i++) got[i] = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (vv[k]) begin
        idx = int'(vid[k]);
        if (idx > 4) ie = 1'b1;
        else if (got[idx]) de = 1'b1;
        else begin
          got[idx] = 1'b1; b[idx] = vval[k]; n_got++;
        end
      end
      if (n_got == 5) begin
        kd = k; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_ballot(input bit start_in_done, input string name);
    logic [4:0] eb;
    bit eto, ede, eie;
    int kd, n;
    model(eb, eto, ede, eie, kd);
    start      = 1'b1;
    vote_valid = 1'($urandom_range(0, 1));
    vote_id    = 3'($urandom_range(0, 7));
    vote_val   = 1'($urandom_range(0, 1));
    check_eq({name, "_idle_ready"}, vote_ready, 0);
    check_eq({name, "_idle_busy"}, busy, 0);
    @(posedge clk); #1;
    n = 0;
    while (!ballot_valid && n < T + 2) begin
      start      = 1'($urandom_range(0, 1));
      vote_valid = (n < T) ? vv[n] : 1'b0;
      vote_id    = (n < T) ? vid[n] : 3'd0;
      vote_val   = (n < T) ? vval[n] : 1'b0;
      check_eq({name, "_col_ready"}, vote_ready, 1);
      check_eq({name, "_col_busy"}, busy, 1);
      @(posedge clk); #1;
      n++;
    end
    vote_valid = 1'b0;
    start      = start_in_done;
    check_eq({name, "_latency"}, n, kd + 1);
    check_eq({name, "_done_valid"}, ballot_valid, 1);
    check_eq({name, "_ballot"}, ballot, eb);
    check_eq({name, "_timed_out"}, timed_out, eto);
    check_eq({name, "_dup_err"}, dup_err, ede);
    check_eq({name, "_id_err"}, id_err, eie);
    check_eq({name, "_done_ready"}, vote_ready, 0);
    check_eq({name, "_done_busy"}, busy, 0);
    n_txn++;
    $display("txn %0d %s: ballot=%b exp=%b cycles=%0d to=%b dup=%b id=%b",
             n_txn, name, ballot, eb, n, timed_out, dup_err, id_err);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq({name, "_post_valid"}, ballot_valid, 0);
    check_eq({name, "_no_restart"}, busy, 0);
    repeat (2) begin
      vote_valid = 1'b1;
      vote_id    = 3'($urandom_range(0, 4));
      vote_val   = 1'($urandom_range(0, 1));
      check_eq({name, "_idle_ready2"}, vote_ready, 0);
      @(posedge clk); #1;
    end
    vote_valid = 1'b0;
    check_eq({name, "_ballot_hold"}, ballot, eb);
    check_eq({name, "_idle_busy2"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vote_valid = 1'b0; vote_id = 3'd0; vote_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ballot", ballot, 0);
    check_eq("rst_valid", ballot_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", vote_ready, 0);
    check_eq("rst_flags", {timed_out, dup_err, id_err}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a collection.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; vote_valid = 1'b1; vote_id = 3'd1; vote_val = 1'b1;
    @(posedge clk); #1;
    vote_val = 1'b0;
    @(posedge clk); #1;
    vote_valid = 1'b0;
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_dup", dup_err, 1);
    check_eq("pre_rst_ballot", ballot, 5'b00010);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_ballot", ballot, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", vote_ready, 0);
    check_eq("mid_rst_dup", dup_err, 0);
    check_eq("mid_rst_valid", ballot_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_valid", ballot_valid, 0);

    // Full ballot, back to back.
    clear_stim();
    set_vote(0, 0, 1); set_vote(1, 1, 0); set_vote(2, 2, 1); set_vote(3, 3, 1); set_vote(4, 4, 0);
    run_ballot(1'b1, "full");
    check_eq("full_majority", 32'($countones(ballot) >= 3), 1);

    // Duplicate and out-of-range id.
    clear_stim();
    set_vote(0, 2, 1); set_vote(1, 2, 0); set_vote(2, 6, 1);
    set_vote(3, 0, 0); set_vote(4, 1, 0); set_vote(5, 3, 0); set_vote(6, 4, 0);
    run_ballot(1'b0, "dupid");

    // Timeout with only voters 0 and 1.
    clear_stim();
    set_vote(0, 0, 1); set_vote(1, 1, 1);
    run_ballot(1'b1, "timeout");

    // Fifth vote lands on the last window cycle.
    clear_stim();
    set_vote(0, 0, 1); set_vote(1, 1, 1); set_vote(2, 2, 0); set_vote(3, 3, 0); set_vote(9, 4, 1);
    run_ballot(1'b1, "race");

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < T; k++) begin
        vv[k]   = ($urandom_range(0, 99) < 70);
        vid[k]  = ($urandom_range(0, 99) < 85) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        vval[k] = 1'($urandom_range(0, 1));
      end
      run_ballot(1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ballot_collector.md
Name: ballot_collector

Overview:
- Upstream stage for the 5-input majority voter. Collects five single-bit votes serially over a valid/ready handshake and assembles them into a 5-bit ballot vector. Presents the ballot with a one-cycle valid strobe, ready for combinational majority evaluation downstream.
- Handles missing voters (timeout; absent votes count as 0), duplicate votes and out-of-range voter IDs.

Parameters:
- NUM_VOTERS, 5, voter count; fixed at 5 to match the downstream voter; other values unsupported.
- TIMEOUT_CYCLES, 255, COLLECT cycles allowed before the ballot closes; legal range 1..255.
- TMR_W, 8, timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  opens a new ballot; sampled only in IDLE.
- vote_valid  input  1  vote_id/vote_val are valid.
- vote_id  input  3  voter index; 0..4 legal.
- vote_val  input  1  vote value.
- vote_ready  output  1  block accepts a vote this cycle.
- ballot  output  5  assembled votes; bit i is voter i; feeds majority input x[4:0].
- ballot_valid  output  1  one-cycle strobe; ballot is complete.
- busy  output  1  state is COLLECT.
- timed_out  output  1  sticky; last ballot closed by timeout.
- dup_err  output  1  sticky; a duplicate vote was rejected.
- id_err  output  1  sticky; a vote_id greater than 4 was rejected.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset (async, immediate): state=IDLE; ballot=0, mask=0, timer=0, ballot_valid=0, timed_out=0, dup_err=0, id_err=0.
  - Reset asserted mid-COLLECT discards the partial ballot; no ballot_valid is produced.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - vote_ready=0; votes are ignored.
  - start=1 -> COLLECT next cycle. Same edge clears ballot, mask, timer, timed_out, dup_err and id_err.
- COLLECT:
  - vote_ready=1 (combinational decode of state); busy=1.
  - Accept = vote_valid & vote_ready.
  - vote_id>4: vote dropped, id_err<=1.
  - mask[vote_id]=1 already: vote dropped, dup_err<=1; the first value is kept.
  - Otherwise: ballot[vote_id]<=vote_val and mask[vote_id]<=1.
  - timer increments every COLLECT cycle.
  - Next mask all-ones -> DONE next cycle.
  - Else timer==TIMEOUT_CYCLES-1 -> DONE next cycle with timed_out<=1; unreceived bits stay 0.
  - Simultaneous fifth vote and timeout: the vote is accepted and timed_out stays 0.
  - start is ignored in COLLECT.
- DONE (exactly one cycle):
  - ballot_valid=1, vote_ready=0, then IDLE.
  - start in DONE is ignored.
- Latency: the fifth vote accepted at edge N -> ballot_valid high during cycle N+1. Fastest ballot: start cycle + 5 vote cycles + 1 DONE cycle = 7 cycles.
- ballot holds its value after DONE until the next accepted start, so the downstream majority output stays stable.
- ballot_valid, busy and vote_ready are glitch-free decodes of the registered state.

Decomposition:
- Shared package ballot_pkg:
  - state enum {IDLE, COLLECT, DONE}.
  - NUM_VOTERS and VOTER_ID_MAX=4.
  - TIMEOUT default.
- One sub-module, ballot_timeout_ctr: TMR_W-bit counter with clear, enable and terminal-count flag (tc at TIMEOUT_CYCLES-1).
- The majority decision stays in its existing combinational block; it is not duplicated here.

Test Plan:
- Reset mid-COLLECT: start, two votes, assert rst -> all outputs 0 immediately, IDLE; a later start yields a clean ballot with no flags.
- Full ballot: start, then votes (id,val) = (0,1),(1,0),(2,1),(3,1),(4,0) back-to-back -> ballot=5'b01101, ballot_valid for exactly one cycle, 1 cycle after the last vote; downstream majority output=1.
- Duplicate and bad ID: start; vote (2,1), then (2,0), then id 6; then ids 0,1,3,4 all 0 -> ballot=5'b00100, dup_err=1, id_err=1, ballot_valid once.
- Timeout: TIMEOUT_CYCLES=10; start; votes only from ids 0 and 1 with val 1 -> ballot_valid 10 cycles after COLLECT entry, ballot=5'b00011, timed_out=1.
- Race: TIMEOUT_CYCLES=10; fifth vote accepted on the timeout cycle -> timed_out=0 and complete ballot. Separately: start held high through COLLECT/DONE, and vote_valid driven in IDLE -> no restart, no vote accepted, vote_ready=0 outside COLLECT.
